// File: rtl/voice_allocator_pkg.sv
// Shared types and width constants for the voice allocator: FSM encoding,
// pending-action encoding and default key/velocity/rank widths.
package voice_allocator_pkg;

   localparam int NUM_CHANNELS_DEF = 16;
   localparam int KEY_BITS_DEF     = 7;
   localparam int VEL_BITS_DEF     = 7;

   // Rank width never drops below one bit so a single-voice build still has a legal vector.
   function automatic int rank_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int RANK_BITS_DEF = rank_bits(NUM_CHANNELS_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_WRITE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_ON   = 2'd1,
      ACT_OFF  = 2'd2
   } act_t;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational channel picker: held-key match first, then lowest free
// released channel, otherwise the least-recently-used voice.
module voice_select
   import voice_allocator_pkg::*;
#(
   parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
   parameter int KEY_BITS     = KEY_BITS_DEF,
   parameter int RANK_BITS    = RANK_BITS_DEF
) (
   input  logic [NUM_CHANNELS*KEY_BITS-1:0]  keys_i,
   input  logic [NUM_CHANNELS-1:0]           gates_i,
   input  logic [NUM_CHANNELS-1:0]           avail_i,
   input  logic [NUM_CHANNELS*RANK_BITS-1:0] ranks_i,
   input  logic [KEY_BITS-1:0]               key_i,
   output logic [RANK_BITS-1:0]              target_o,
   output logic                              hit_o,
   output logic                              free_o,
   output logic                              steal_o
);

   logic [RANK_BITS-1:0] hit_idx, free_idx, old_idx;
   logic                 hit_f, free_f, old_f;

   // Scanning downward leaves the lowest matching index as the final winner.
   always_comb begin
      hit_idx  = '0;
      free_idx = '0;
      old_idx  = '0;
      hit_f    = 1'b0;
      free_f   = 1'b0;
      old_f    = 1'b0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (gates_i[i] && (keys_i[i*KEY_BITS +: KEY_BITS] == key_i)) begin
            hit_f   = 1'b1;
            hit_idx = RANK_BITS'(i);
         end
         if (!gates_i[i] && avail_i[i]) begin
            free_f   = 1'b1;
            free_idx = RANK_BITS'(i);
         end
         if (ranks_i[i*RANK_BITS +: RANK_BITS] == RANK_BITS'(NUM_CHANNELS - 1)) begin
            old_f   = 1'b1;
            old_idx = RANK_BITS'(i);
         end
      end
   end

   always_comb begin
      hit_o   = hit_f;
      free_o  = !hit_f && free_f;
      steal_o = !hit_f && !free_f && old_f;
      if (hit_f) begin
         target_o = hit_idx;
      end else if (free_f) begin
         target_o = free_idx;
      end else begin
         target_o = old_idx;
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events through a three-state
// IDLE/SEARCH/WRITE sequence and maintains per-channel key, tuning, velocity, gate and LRU rank.
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
   parameter int NUM_BITS     = 32,
   parameter int KEY_BITS     = KEY_BITS_DEF,
   parameter int VEL_BITS     = VEL_BITS_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ev_valid,
   output logic                             ev_ready,
   input  logic                             ev_note_on,
   input  logic [KEY_BITS-1:0]              ev_key,
   input  logic [VEL_BITS-1:0]              ev_velocity,
   input  logic [NUM_BITS-1:0]              ev_car_word,
   input  logic [NUM_BITS-1:0]              ev_mod_word,
   input  logic                             panic,
   input  logic [NUM_CHANNELS-1:0]          available,
   output logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out,
   output logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out,
   output logic [NUM_BITS*NUM_CHANNELS-1:0] velocity_out,
   output logic [NUM_CHANNELS-1:0]          gate_out,
   output logic [1:0]                       dbg_state
);

   localparam int RANK_BITS = rank_bits(NUM_CHANNELS);

   // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
   // ev_ready is high only in IDLE without panic, so fields are held by the source until then.
   state_t state_q, state_d;
   logic   accept;

   logic [KEY_BITS-1:0]  evt_key_q;
   logic [VEL_BITS-1:0]  evt_vel_q;
   logic [NUM_BITS-1:0]  evt_car_q;
   logic [NUM_BITS-1:0]  evt_mod_q;
   logic                 evt_on_q;
   logic [RANK_BITS-1:0] tgt_q;
   act_t                 act_q;

   logic [KEY_BITS-1:0]  ch_key_q [NUM_CHANNELS];
   logic [NUM_BITS-1:0]  ch_car_q [NUM_CHANNELS];
   logic [NUM_BITS-1:0]  ch_mod_q [NUM_CHANNELS];
   logic [NUM_BITS-1:0]  ch_vel_q [NUM_CHANNELS];
   logic [RANK_BITS-1:0] rank_q   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] gate_q;

   logic [NUM_CHANNELS*KEY_BITS-1:0]  keys_flat;
   logic [NUM_CHANNELS*RANK_BITS-1:0] ranks_flat;
   logic [RANK_BITS-1:0]              sel_target;
   logic                              sel_hit, sel_free, sel_steal;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      assign carrier_out[c*NUM_BITS +: NUM_BITS]   = ch_car_q[c];
      assign modulator_out[c*NUM_BITS +: NUM_BITS] = ch_mod_q[c];
      assign velocity_out[c*NUM_BITS +: NUM_BITS]  = ch_vel_q[c];
      assign keys_flat[c*KEY_BITS +: KEY_BITS]     = ch_key_q[c];
      assign ranks_flat[c*RANK_BITS +: RANK_BITS]  = rank_q[c];
   end

   assign gate_out  = gate_q;
   assign dbg_state = state_q;

   voice_select #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .KEY_BITS     (KEY_BITS),
      .RANK_BITS    (RANK_BITS)
   ) u_select (
      .keys_i   (keys_flat),
      .gates_i  (gate_q),
      .avail_i  (available),
      .ranks_i  (ranks_flat),
      .key_i    (evt_key_q),
      .target_o (sel_target),
      .hit_o    (sel_hit),
      .free_o   (sel_free),
      .steal_o  (sel_steal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ev_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ev_ready = !panic;
            if (ev_valid && !panic) state_d = ST_SEARCH;
         end
         ST_SEARCH: state_d = ST_WRITE;
         ST_WRITE:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (panic) state_d = ST_IDLE;
   end

   assign accept = ev_valid && ev_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_key_q <= '0;
         evt_vel_q <= '0;
         evt_car_q <= '0;
         evt_mod_q <= '0;
         evt_on_q  <= 1'b0;
         tgt_q     <= '0;
         act_q     <= ACT_NONE;
         gate_q    <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_key_q[i] <= '0;
            ch_car_q[i] <= '0;
            ch_mod_q[i] <= '0;
            ch_vel_q[i] <= '0;
            rank_q[i]   <= RANK_BITS'(i);
         end
      end else begin
         if (accept) begin
            evt_key_q <= ev_key;
            evt_vel_q <= ev_velocity;
            evt_car_q <= ev_car_word;
            evt_mod_q <= ev_mod_word;
            // A zero-velocity note-on is a note-off in MIDI running-status practice.
            evt_on_q  <= ev_note_on && (ev_velocity != '0);
         end

         if (state_q == ST_SEARCH) begin
            tgt_q <= sel_target;
            if (evt_on_q) begin
               act_q <= (sel_hit || sel_free || sel_steal) ? ACT_ON : ACT_NONE;
            end else begin
               act_q <= sel_hit ? ACT_OFF : ACT_NONE;
            end
         end

         // Panic wins over a pending write; slots and ranks are left as they are.
         if (panic) begin
            gate_q <= '0;
         end else if (state_q == ST_WRITE) begin
            if (act_q == ACT_ON) begin
               ch_key_q[tgt_q] <= evt_key_q;
               ch_car_q[tgt_q] <= evt_car_q;
               ch_mod_q[tgt_q] <= evt_mod_q;
               ch_vel_q[tgt_q] <= {{(NUM_BITS-VEL_BITS){1'b0}}, evt_vel_q};
               gate_q[tgt_q]   <= 1'b1;
               for (int i = 0; i < NUM_CHANNELS; i++) begin
                  if (rank_q[i] < rank_q[tgt_q]) rank_q[i] <= rank_q[i] + RANK_BITS'(1);
               end
               rank_q[tgt_q] <= '0;
            end else if (act_q == ACT_OFF) begin
               gate_q[tgt_q] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: table-driven event vectors with a
// latency-aligned scoreboard, plus hand-written steal and panic sequences.
module tb_voice_allocator;
   import voice_allocator_pkg::*;

   localparam int NC   = 16;
   localparam int NB   = 32;
   localparam int KB   = 7;
   localparam int VB   = 7;
   localparam int SB_W = 4 + 1 + 32 + 32 + 32 + 16;

   logic            clk;
   logic            rst;
   logic            ev_valid;
   logic            ev_ready;
   logic            ev_note_on;
   logic [KB-1:0]   ev_key;
   logic [VB-1:0]   ev_velocity;
   logic [NB-1:0]   ev_car_word;
   logic [NB-1:0]   ev_mod_word;
   logic            panic;
   logic [NC-1:0]   available;
   logic [NB*NC-1:0] carrier_out;
   logic [NB*NC-1:0] modulator_out;
   logic [NB*NC-1:0] velocity_out;
   logic [NC-1:0]   gate_out;
   logic [1:0]      dbg_state;

   voice_allocator #(
      .NUM_CHANNELS (NC),
      .NUM_BITS     (NB),
      .KEY_BITS     (KB),
      .VEL_BITS     (VB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_note_on    (ev_note_on),
      .ev_key        (ev_key),
      .ev_velocity   (ev_velocity),
      .ev_car_word   (ev_car_word),
      .ev_mod_word   (ev_mod_word),
      .panic         (panic),
      .available     (available),
      .carrier_out   (carrier_out),
      .modulator_out (modulator_out),
      .velocity_out  (velocity_out),
      .gate_out      (gate_out),
      .dbg_state     (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        on;
      logic [6:0]  key;
      logic [6:0]  vel;
      logic [31:0] car;
      logic [31:0] modw;
      logic [15:0] avail;
      int          exp_ch;
      logic        exp_gate;
      logic [31:0] exp_car;
      logic [31:0] exp_mod;
      logic [31:0] exp_vel;
      logic [15:0] exp_gates;
   } vec_t;

   int tests  = 0;
   int failed = 0;
   logic [SB_W-1:0] exp_q[$];
   vec_t vecs[9];

   function automatic vec_t mk(input logic on, input int key, input int vel,
                               input logic [31:0] car, input logic [31:0] modw,
                               input logic [15:0] avail, input int ch, input logic g,
                               input logic [31:0] ecar, input logic [31:0] emod,
                               input int evel, input logic [15:0] egates);
      vec_t v;
      v.on = on; v.key = 7'(key); v.vel = 7'(vel); v.car = car; v.modw = modw;
      v.avail = avail; v.exp_ch = ch; v.exp_gate = g; v.exp_car = ecar;
      v.exp_mod = emod; v.exp_vel = 32'(evel); v.exp_gates = egates;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ev_valid = 1'b0; panic = 1'b0; available = '1;
      ev_note_on = 1'b0; ev_key = '0; ev_velocity = '0; ev_car_word = '0; ev_mod_word = '0;
      step(3);
      rst = 1'b0;
   endtask

   // Driver: waits (bounded) for ready, then holds one event for exactly one accepting edge.
   task automatic drive_event(input logic on, input logic [6:0] key, input logic [6:0] vel,
                              input logic [31:0] car, input logic [31:0] modw);
      int budget = 0;
      while (!ev_ready && budget < 50) begin
         step(1);
         budget++;
      end
      if (!ev_ready) begin
         tests++;
         failed++;
         $display("FAIL ready_timeout: got ev_ready=0 expected 1 within 50 cycles");
      end
      ev_valid = 1'b1; ev_note_on = on; ev_key = key; ev_velocity = vel;
      ev_car_word = car; ev_mod_word = modw;
      step(1);
      ev_valid = 1'b0;
   endtask

   task automatic check_out(input string tag);
      logic [SB_W-1:0] e;
      int ch;
      if (exp_q.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL %s_sb_empty: got empty queue expected an entry", tag);
         return;
      end
      e  = exp_q.pop_front();
      ch = int'(e[116:113]);
      chk({tag, "_gate"},  32'(gate_out[ch]), 32'(e[112]));
      chk({tag, "_car"},   carrier_out[ch*NB +: NB],   e[111:80]);
      chk({tag, "_mod"},   modulator_out[ch*NB +: NB], e[79:48]);
      chk({tag, "_vel"},   velocity_out[ch*NB +: NB],  e[47:16]);
      chk({tag, "_gates"}, 32'(gate_out), 32'(e[15:0]));
      chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
   endtask

   // Event accepted at edge E0; channel state is visible right after E2.
   task automatic apply(input vec_t v, input string tag);
      available = v.avail;
      drive_event(v.on, v.key, v.vel, v.car, v.modw);
      exp_q.push_back({4'(v.exp_ch), v.exp_gate, v.exp_car, v.exp_mod, v.exp_vel, v.exp_gates});
      step(2);
      check_out(tag);
   endtask

   initial begin
      vecs[0] = mk(1, 60, 100, 32'h11111, 32'h22222, 16'hFFFF, 0, 1, 32'h11111, 32'h22222, 100, 16'h0001);
      vecs[1] = mk(1, 60,  90, 32'h33333, 32'h44444, 16'hFFFF, 0, 1, 32'h33333, 32'h44444,  90, 16'h0001);
      vecs[2] = mk(1, 60,   0, 32'h55555, 32'h66666, 16'hFFFF, 0, 0, 32'h33333, 32'h44444,  90, 16'h0000);
      vecs[3] = mk(0, 61,   0, 32'h77777, 32'h77777, 16'hFFFF, 0, 0, 32'h33333, 32'h44444,  90, 16'h0000);
      vecs[4] = mk(1, 62,  50, 32'h88888, 32'h99999, 16'hFFFE, 1, 1, 32'h88888, 32'h99999,  50, 16'h0002);
      vecs[5] = mk(1, 63,   1, 32'hAAAAA, 32'hBBBBB, 16'hFFFF, 0, 1, 32'hAAAAA, 32'hBBBBB,   1, 16'h0003);
      vecs[6] = mk(0, 62,  20, 32'h0,     32'h0,     16'hFFFF, 1, 0, 32'h88888, 32'h99999,  50, 16'h0001);
      vecs[7] = mk(1, 63, 127, 32'hCCCCC, 32'hDDDDD, 16'h0000, 0, 1, 32'hCCCCC, 32'hDDDDD, 127, 16'h0001);
      vecs[8] = mk(1, 65,   5, 32'hEEEEE, 32'hFFFFF, 16'h0000, 15, 1, 32'hEEEEE, 32'hFFFFF,  5, 16'h8001);

      // Reset state
      do_reset();
      chk("rst_ready", 32'(ev_ready), 32'd1);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rst_gates", 32'(gate_out), 32'd0);
      chk("rst_car_or", 32'(|carrier_out), 32'd0);
      chk("rst_mod_or", 32'(|modulator_out), 32'd0);
      chk("rst_vel_or", 32'(|velocity_out), 32'd0);

      // Table: retrigger, zero-velocity off, unmatched off, availability, steal by rank
      for (int i = 0; i < 9; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Fill all voices, then steal the oldest twice, then retrigger a held key
      do_reset();
      for (int k = 0; k < 17; k++) begin
         int ch;
         logic [15:0] g;
         ch = (k < 16) ? k : 0;
         g  = (k < 16) ? 16'((32'd1 << (k + 1)) - 1) : 16'hFFFF;
         apply(mk(1, 40 + k, 10 + k, 32'(1000 + k), 32'(2000 + k), 16'hFFFF,
                  ch, 1, 32'(1000 + k), 32'(2000 + k), 10 + k, g), $sformatf("fill%0d", k));
      end
      apply(mk(1, 57, 70, 32'h5757, 32'h7575, 16'hFFFF, 1, 1, 32'h5757, 32'h7575, 70, 16'hFFFF), "steal2");
      apply(mk(1, 45, 99, 32'h4545, 32'h5454, 16'hFFFF, 5, 1, 32'h4545, 32'h5454, 99, 16'hFFFF), "retrig45");

      // Panic during SEARCH aborts the in-flight note-on
      do_reset();
      apply(mk(1, 10, 30, 32'h10, 32'h11, 16'hFFFF, 0, 1, 32'h10, 32'h11, 30, 16'h0001), "p_pre");
      drive_event(1, 7'd64, 7'd70, 32'h640, 32'h641);
      chk("p_in_search", 32'(dbg_state), 32'(ST_SEARCH));
      panic = 1'b1;
      step(1);
      chk("p_gates_clear", 32'(gate_out), 32'd0);
      chk("p_ready_low", 32'(ev_ready), 32'd0);
      chk("p_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      panic = 1'b0;
      step(1);
      chk("p_ready_back", 32'(ev_ready), 32'd1);
      step(3);
      chk("p_ch1_car", carrier_out[1*NB +: NB], 32'h0);
      chk("p_gates_stay", 32'(gate_out), 32'd0);
      chk("p_ch0_car_kept", carrier_out[0*NB +: NB], 32'h10);
      apply(mk(1, 66, 12, 32'h66, 32'h67, 16'hFFFF, 0, 1, 32'h66, 32'h67, 12, 16'h0001), "p_post");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 16, number of synth voices (channels).
REQ-002 SHALL have parameter NUM_BITS, default 32, width of one tuning-word or velocity slot per channel.
REQ-003 SHALL have parameter KEY_BITS, default 7, MIDI key number width.
REQ-004 SHALL have parameter VEL_BITS, default 7, MIDI velocity width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ev_valid  input  1  note event offered.
REQ-008 ev_ready  output  1  allocator can accept an event this cycle.
REQ-009 ev_note_on  input  1  1 = note-on, 0 = note-off.
REQ-010 ev_key  input  KEY_BITS  MIDI key of event.
REQ-011 ev_velocity  input  VEL_BITS  MIDI velocity of event.
REQ-012 ev_car_word  input  NUM_BITS  carrier tuning word for ev_key.
REQ-013 ev_mod_word  input  NUM_BITS  modulator tuning word for ev_key.
REQ-014 panic  input  1  all-notes-off request.
REQ-015 available  input  NUM_CHANNELS  per channel, 1 = envelope fully released.
REQ-016 carrier_out  output  NUM_BITS*NUM_CHANNELS  channel c in bits [c*NUM_BITS +: NUM_BITS].
REQ-017 modulator_out  output  NUM_BITS*NUM_CHANNELS  same packing as carrier_out.
REQ-018 velocity_out  output  NUM_BITS*NUM_CHANNELS  same packing; velocity zero-extended to NUM_BITS.
REQ-019 gate_out  output  NUM_CHANNELS  per channel, 1 = key held.

Function
REQ-020 FSM states: IDLE (ev_ready=1), SEARCH (evaluate match/free/steal), WRITE (update channel state); IDLE->SEARCH on ev_valid&ev_ready, SEARCH->WRITE always, WRITE->IDLE always.
REQ-021 Accept in cycle N: event fields captured at N, outputs reflect the event from cycle N+3 (registered after WRITE); throughput one event per 3 cycles.
REQ-022 ev_ready SHALL be 1 only in IDLE and when panic=0.
REQ-023 Note-on with ev_velocity=0 SHALL be processed as note-off.
REQ-024 Note-on target priority: (a) lowest-index channel whose stored key = ev_key and gate=1 (retrigger); else (b) lowest-index channel with gate=0 and available=1; else (c) channel with LRU rank NUM_CHANNELS-1 (steal).
REQ-025 Note-on write: target key, carrier, modulator, velocity slots loaded; gate set to 1.
REQ-026 LRU: each channel holds rank 0..NUM_CHANNELS-1, unique; on note-on to channel with rank r, channels with rank < r increment, target becomes 0; note-off leaves ranks unchanged.
REQ-027 Note-off: lowest-index channel with gate=1 and matching key has gate cleared; tuning/velocity slots retained (release tail); no match -> event dropped, no state change.
REQ-028 panic=1 SHALL clear all gate bits at the next edge, in any state, and abort any event in SEARCH/WRITE (FSM -> IDLE, event discarded); slots and ranks retained.
REQ-029 available is sampled in SEARCH only; changes in other cycles do not affect the in-flight decision.
REQ-030 Duplicate note-on for a held key SHALL never occupy a second channel.

Reset
REQ-031 On rst: FSM=IDLE, ev_ready=1 in the first cycle after rst deasserts, gate_out=0, carrier_out/modulator_out/velocity_out=0, stored keys=0, rank of channel c = c.
REQ-032 rst SHALL take priority over panic and over any event in flight.

Structure
REQ-033 Shared package holds FSM state encoding, KEY_BITS/VEL_BITS defaults and rank width constant clog2(NUM_CHANNELS).
REQ-034 One sub-module voice_select: combinational priority encoder producing target index and hit/free/steal flags from keys, gates, available, ranks.

Verification
REQ-035 Reset, then note-on key 60 vel 100 -> channel 0 gate=1, velocity slot 100, carrier slot = ev_car_word, at accept+3 cycles.
REQ-036 17 distinct note-ons (keys 40..56), available all 1 -> channels 0..15 filled; 17th (key 56) steals channel 0 (oldest), gate stays 1.
REQ-037 Note-on key 60 twice -> only channel 0 used, slots rewritten, rank of channel 0 = 0.
REQ-038 Note-on key 60 then note-on key 60 vel 0 -> channel 0 gate=0, carrier slot unchanged; note-off key 61 -> no change.
REQ-039 Note-off key 60 with available[0]=0 then note-on key 62 -> goes to channel 1, not 0.
REQ-040 panic asserted during SEARCH of note-on key 64 -> all gates 0 next cycle, key 64 not allocated, ev_ready=1 one cycle after panic deasserts.
